// File: rtl/fb_scanout_if.sv
// Framebuffer scanout bus: control inputs, framebuffer read port and
// the VGA-side timing/pixel outputs, bundled between scanout and its user.
interface fb_scanout_if;
  logic       enable;
  logic       buf_sel;
  logic       rd_en;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic       rd_buf;
  logic [3:0] rd_data;
  logic       hsync_n;
  logic       vsync_n;
  logic       de;
  logic [3:0] pixel;
  logic       vblank;
  logic       frame_start;

  modport master (
    input  enable, buf_sel, rd_data,
    output rd_en, rd_x, rd_y, rd_buf, hsync_n, vsync_n, de, pixel,
           vblank, frame_start
  );

  modport slave (
    output enable, buf_sel, rd_data,
    input  rd_en, rd_x, rd_y, rd_buf, hsync_n, vsync_n, de, pixel,
           vblank, frame_start
  );
endinterface

// File: rtl/fb_scanout.sv
// VGA scanout of a 4-bit framebuffer. Generates raster timing, issues one
// read per visible pixel, and delays sync/blank by the memory read latency
// so they line up with the returned data.
//
// state | meaning
// IDLE  | counters parked at 0, no reads, outputs idle
// RUN   | scanning frames continuously
// DRAIN | stop requested; finish the current frame, then IDLE
module fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 2
) (
  input logic          clk,
  input logic          areset,
  fb_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [9:0]            h_cnt;
  logic [9:0]            v_cnt;
  logic [RD_LATENCY-1:0] act_sr;
  logic [RD_LATENCY-1:0] hs_sr;
  logic [RD_LATENCY-1:0] vs_sr;
  logic                  buf_q;

  logic running;
  logic active;
  logic hs0;
  logic vs0;
  logic at_last;
  logic frame_start;

  // Stage-0 decode straight from the registered counters.
  always_comb begin
    running     = (state != IDLE);
    active      = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0         = running && (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs0         = running && (v_cnt >= VS_START) && (v_cnt < VS_END);
    at_last     = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    frame_start = running && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  // Scan state and raster counters; a stop only lands at the frame wrap.
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (bus.enable) state <= RUN;
        end
        RUN, DRAIN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
          end else begin
            h_cnt <= h_cnt + 10'd1;
          end
          if (state == RUN) begin
            if (!bus.enable) state <= DRAIN;
          end else if (bus.enable) begin
            state <= RUN;
          end else if (at_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay active/sync by the read latency; keeps shifting in IDLE to flush.
  always_ff @(posedge clk) begin
    if (areset) begin
      act_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
    end else begin
      act_sr[0] <= active;
      hs_sr[0]  <= hs0;
      vs_sr[0]  <= vs0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        act_sr[i] <= act_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
      end
    end
  end

  // Front-buffer select captured once per frame.
  always_ff @(posedge clk) begin
    if (areset) begin
      buf_q <= 1'b0;
    end else if (frame_start) begin
      buf_q <= bus.buf_sel;
    end
  end

  // The first read of a frame already targets the newly selected buffer.
  assign bus.rd_buf      = frame_start ? bus.buf_sel : buf_q;
  assign bus.rd_en       = active;
  assign bus.rd_x        = active ? h_cnt : 10'd0;
  assign bus.rd_y        = active ? v_cnt[8:0] : 9'd0;
  assign bus.de          = act_sr[RD_LATENCY-1];
  assign bus.hsync_n     = ~hs_sr[RD_LATENCY-1];
  assign bus.vsync_n     = ~vs_sr[RD_LATENCY-1];
  assign bus.pixel       = act_sr[RD_LATENCY-1] ? bus.rd_data : 4'd0;
  assign bus.vblank      = (state == IDLE) || (v_cnt >= V_ACT);
  assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a shrunken raster (35x19) so several whole
// frames fit in a short run. A linear-position reference model predicts
// every output each cycle; directed scenarios add literal timing checks.
module tb_fb_scanout;
  localparam int HA = 20, HFP = 4, HS = 6, HBP = 5;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int RDL = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic areset;
  fb_scanout_if bus();

  int n_tests = 0;
  int n_fail  = 0;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .RD_LATENCY(RDL)
  ) dut (
    .clk(clk),
    .areset(areset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] fb(input int x, input int y);
    int t;
    t = x + 2 * y + 1;
    return t[3:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Framebuffer model: answers each read RDL cycles later, junk otherwise.
  logic       q_en [RDL];
  logic [9:0] q_x  [RDL];
  logic [8:0] q_y  [RDL];
  always @(posedge clk) begin
    q_en[0] <= bus.rd_en;
    q_x[0]  <= bus.rd_x;
    q_y[0]  <= bus.rd_y;
    for (int i = 1; i < RDL; i++) begin
      q_en[i] <= q_en[i-1];
      q_x[i]  <= q_x[i-1];
      q_y[i]  <= q_y[i-1];
    end
  end
  assign bus.rd_data = (q_en[RDL-1] === 1'b1) ?
                       fb(int'(q_x[RDL-1]), int'(q_y[RDL-1])) : 4'hF;

  // Reference model: scan position as one linear index within the frame.
  bit m_run, m_drain, m_buf, chk_on;
  int m_pos;
  bit da [RDL];
  bit dh [RDL];
  bit dv [RDL];
  int dx [RDL];
  int dy [RDL];

  int e_h, e_v;
  logic e_act, e_hs, e_vs, e_fs, e_vblank;
  assign e_h      = m_pos % HT;
  assign e_v      = m_pos / HT;
  assign e_act    = m_run && (e_h < HA) && (e_v < VA);
  assign e_hs     = m_run && (e_h >= HA + HFP) && (e_h < HA + HFP + HS);
  assign e_vs     = m_run && (e_v >= VA + VFP) && (e_v < VA + VFP + VS);
  assign e_fs     = m_run && (m_pos == 0);
  assign e_vblank = !m_run || (e_v >= VA);

  // Advance the model on each clock.
  always @(posedge clk) begin
    if (areset) begin
      chk_on  <= 1'b1;
      m_run   <= 1'b0;
      m_drain <= 1'b0;
      m_pos   <= 0;
      m_buf   <= 1'b0;
      for (int i = 0; i < RDL; i++) begin
        da[i] <= 1'b0; dh[i] <= 1'b0; dv[i] <= 1'b0; dx[i] <= 0; dy[i] <= 0;
      end
    end else begin
      da[0] <= e_act; dh[0] <= e_hs; dv[0] <= e_vs; dx[0] <= e_h; dy[0] <= e_v;
      for (int i = 1; i < RDL; i++) begin
        da[i] <= da[i-1]; dh[i] <= dh[i-1]; dv[i] <= dv[i-1];
        dx[i] <= dx[i-1]; dy[i] <= dy[i-1];
      end
      if (e_fs) m_buf <= bus.buf_sel;
      if (!m_run) begin
        if (bus.enable) begin
          m_run   <= 1'b1;
          m_drain <= 1'b0;
          m_pos   <= 0;
        end
      end else begin
        m_pos <= (m_pos == FRAME - 1) ? 0 : m_pos + 1;
        if (!m_drain) begin
          m_drain <= !bus.enable;
        end else if (bus.enable) begin
          m_drain <= 1'b0;
        end else if (m_pos == FRAME - 1) begin
          m_run   <= 1'b0;
          m_drain <= 1'b0;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_en",       16'(bus.rd_en),       16'(e_act));
      chk("rd_x",        16'(bus.rd_x),        e_act ? 16'(e_h) : 16'd0);
      chk("rd_y",        16'(bus.rd_y),        e_act ? 16'(e_v) : 16'd0);
      chk("frame_start", 16'(bus.frame_start), 16'(e_fs));
      chk("vblank",      16'(bus.vblank),      16'(e_vblank));
      chk("rd_buf",      16'(bus.rd_buf),      e_fs ? 16'(bus.buf_sel) : 16'(m_buf));
      chk("de",          16'(bus.de),          16'(da[RDL-1]));
      chk("hsync_n",     16'(bus.hsync_n),     16'(!dh[RDL-1]));
      chk("vsync_n",     16'(bus.vsync_n),     16'(!dv[RDL-1]));
      chk("pixel",       16'(bus.pixel),
          da[RDL-1] ? 16'(fb(dx[RDL-1], dy[RDL-1])) : 16'd0);
    end
  end

  // Frame-start spacing, measured in clock cycles.
  int cyc = 0;
  int prev_fs = 0;
  int fs_gap = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (chk_on && bus.frame_start === 1'b1) begin
      fs_gap  <= cyc - prev_fs;
      prev_fs <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input int max, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_start !== 1'b1 && n < max);
    chk(name, 16'(bus.frame_start), 16'd1);
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, vs_cnt, vs_first, vb_first, period;
    logic [3:0] pix5;

    areset = 1'b1;
    bus.enable = 1'b0;
    bus.buf_sel = 1'b0;
    tick(3);
    areset = 1'b0;
    tick(4);
    @(negedge clk);
    chk("idle_vblank", 16'(bus.vblank), 16'd1);
    chk("idle_hsync_n", 16'(bus.hsync_n), 16'd1);
    chk("idle_rd_en", 16'(bus.rd_en), 16'd0);

    // Start: first RUN cycle reads (0,0); pixel arrives RDL cycles later.
    @(posedge clk); #1;
    bus.enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start_fs", 16'(bus.frame_start), 16'd1);
    chk("start_rd_en", 16'(bus.rd_en), 16'd1);
    chk("start_rd_x", 16'(bus.rd_x), 16'd0);
    chk("start_rd_y", 16'(bus.rd_y), 16'd0);
    repeat (RDL) @(negedge clk);
    chk("start_de", 16'(bus.de), 16'd1);
    chk("start_pixel", 16'(bus.pixel), 16'h1);

    // One line measured from the rise of de.
    de_cnt = 0; hs_cnt = 0; hs_first = -1; pix5 = 4'h0;
    for (int i = 0; i < HT; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.de === 1'b1) de_cnt++;
      if (bus.hsync_n === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (i == 5) pix5 = bus.pixel;
    end
    chk("line_de_cycles", 16'(de_cnt), 16'd20);
    chk("line_hsync_cycles", 16'(hs_cnt), 16'd6);
    chk("line_hsync_offset", 16'(hs_first), 16'd24);
    chk("line_pixel5", 16'(pix5), 16'h6);

    // One whole frame measured from frame_start.
    wait_fs(FRAME + 5, "frame_sync");
    period = 0; vs_cnt = 0; vs_first = -1; vb_first = -1;
    do begin
      @(negedge clk);
      period++;
      if (bus.vsync_n === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = period;
      end
      if (bus.vblank === 1'b1 && vb_first < 0) vb_first = period;
    end while (bus.frame_start !== 1'b1 && period < FRAME + 10);
    chk("frame_period", 16'(period), 16'd665);
    chk("frame_vblank_rise", 16'(vb_first), 16'd420);
    chk("frame_vsync_cycles", 16'(vs_cnt), 16'd70);
    chk("frame_vsync_offset", 16'(vs_first), 16'd492);

    // Buffer swap mid-frame takes effect only at the next frame_start.
    @(posedge clk); #1;
    tick(100);
    bus.buf_sel = 1'b1;
    @(negedge clk);
    chk("swap_held", 16'(bus.rd_buf), 16'd0);
    wait_fs(FRAME + 5, "swap_fs");
    chk("swap_at_fs", 16'(bus.rd_buf), 16'd1);
    @(negedge clk);
    chk("swap_after_fs", 16'(bus.rd_buf), 16'd1);

    // Stop at line 5: the frame completes, then everything goes idle.
    @(posedge clk); #1;
    tick(176);
    bus.enable = 1'b0;
    tick(FRAME);
    de_cnt = 0; hs_cnt = 0; period = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rd_en !== 1'b0 || bus.de !== 1'b0) de_cnt++;
      if (bus.frame_start !== 1'b0) period++;
      if (bus.vblank !== 1'b1 || bus.hsync_n !== 1'b1) hs_cnt++;
    end
    chk("stop_no_reads", 16'(de_cnt), 16'd0);
    chk("stop_no_fs", 16'(period), 16'd0);
    chk("stop_idle_levels", 16'(hs_cnt), 16'd0);

    // Restart, then drop and re-raise enable inside the frame: no gap.
    @(posedge clk); #1;
    bus.enable = 1'b1;
    wait_fs(5, "restart_fs");
    @(posedge clk); #1;
    tick(104);
    bus.enable = 1'b0;
    tick(210);
    bus.enable = 1'b1;
    wait_fs(FRAME + 5, "nogap_fs");
    #1;
    chk("nogap_period", 16'(fs_gap), 16'(FRAME));

    // Re-raise enable exactly on the last position of a draining frame.
    @(posedge clk); #1;
    tick(99);
    bus.enable = 1'b0;
    tick(FRAME - 1 - 100);
    bus.enable = 1'b1;
    wait_fs(3, "lastpos_fs");
    #1;
    chk("lastpos_period", 16'(fs_gap), 16'(FRAME));

    // Reset inside the hsync pulse of line 5.
    @(posedge clk); #1;
    tick(200);
    areset = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    chk("prereset_hsync_n", 16'(bus.hsync_n), 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 16'(bus.rd_en), 16'd0);
    chk("rst_de", 16'(bus.de), 16'd0);
    chk("rst_pixel", 16'(bus.pixel), 16'd0);
    chk("rst_hsync_n", 16'(bus.hsync_n), 16'd1);
    chk("rst_vsync_n", 16'(bus.vsync_n), 16'd1);
    chk("rst_vblank", 16'(bus.vblank), 16'd1);
    chk("rst_fs", 16'(bus.frame_start), 16'd0);
    chk("rst_rd_buf", 16'(bus.rd_buf), 16'd0);
    @(posedge clk); #1;
    bus.enable = 1'b1;
    @(negedge clk);
    chk("rst_priority_fs", 16'(bus.frame_start), 16'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    bus.enable = 1'b0;
    tick(10);
    @(negedge clk);
    chk("post_rst_idle_vblank", 16'(bus.vblank), 16'd1);
    chk("post_rst_idle_rd_en", 16'(bus.rd_en), 16'd0);
    @(posedge clk); #1;
    bus.enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reenable_fs", 16'(bus.frame_start), 16'd1);
    chk("reenable_rd_x", 16'(bus.rd_x), 16'd0);
    chk("reenable_rd_y", 16'(bus.rd_y), 16'd0);
    chk("reenable_rd_buf", 16'(bus.rd_buf), 16'd1);
    tick(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, tests=%0d fails=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
Display-side reader of the 4-bit framebuffer that the rasterizer writes through (x, y, data, we). It generates 640x480 VGA timing, issues one framebuffer read per active pixel, and realigns sync/blank to the memory read latency. It also selects the front buffer once per frame and exposes vblank so the rasterizer side can swap buffers safely.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clk cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
RD_LATENCY, 2, cycles from rd_en to valid rd_data (1..4)

Ports:
clk  in  1  pixel clock, one pixel per cycle
areset  in  1  reset, synchronous, active-high
enable  in  1  request scanout; takes effect only at frame boundaries when stopping
buf_sel  in  1  requested front buffer, sampled at frame start
rd_en  out  1  framebuffer read strobe
rd_x  out  10  read column
rd_y  out  9  read row
rd_buf  out  1  buffer being read this frame
rd_data  in  4  read data, valid RD_LATENCY cycles after rd_en
hsync_n  out  1  horizontal sync, active-low
vsync_n  out  1  vertical sync, active-low
de  out  1  display enable (pixel valid)
pixel  out  4  pixel value, 0 when de=0
vblank  out  1  1 when no active line is being read
frame_start  out  1  one-cycle pulse at h=0, v=0 in RUN

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Counters h_cnt, v_cnt are 10 bits, registered.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0. When enable=1, go to RUN next cycle, with h=0, v=0 in that first RUN cycle.
  - RUN: h increments each cycle and wraps at H_TOTAL-1 to 0. v increments on h wrap and wraps at V_TOTAL-1 to 0. If enable=0, go to DRAIN (counters keep running).
  - DRAIN: counters keep running. If enable=1, return to RUN with no timing disturbance. At h=H_TOTAL-1, v=V_TOTAL-1, go to IDLE.
- Stage 0 (combinational from counters and state):
  - active = (state != IDLE) and h < H_ACTIVE and v < V_ACTIVE.
  - rd_en = active; rd_x = h; rd_y = v[8:0]. rd_x and rd_y are 0 when not active.
  - hs0 = (state != IDLE) and H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vs0 is defined likewise on v.
- Output alignment: active, hs0 and vs0 pass through a RD_LATENCY-deep shift register. At stage RD_LATENCY:
  - de = delayed active; pixel = de ? rd_data : 0 (pixel is combinational from rd_data, gated by registered de).
  - hsync_n = ~delayed hs0; vsync_n = ~delayed vs0.
  - Net latency: counter position to de/pixel = RD_LATENCY cycles.
- The shift register keeps clocking in IDLE, so the outputs flush to idle values RD_LATENCY cycles after entering IDLE.
- rd_buf: loaded from buf_sel in the cycle where frame_start=1, then held for the whole frame. A buf_sel change mid-frame has no effect until the next frame_start.
- vblank = 1 in IDLE, or when v >= V_ACTIVE (undelayed, stage-0 timing).
- frame_start = (state == RUN or DRAIN) and h=0 and v=0.
- Simultaneous events:
  - enable falls in the same cycle as the frame wrap from DRAIN: IDLE wins.
  - enable rises in the same cycle DRAIN reaches the last position: go to RUN, not IDLE. The next cycle is a normal frame_start.
- Reset: areset=1 at any time, including mid-frame, forces the following on the next edge:
  - state=IDLE, h=v=0, shift register cleared, rd_buf=0.
  - Hence rd_en=0, de=0, pixel=0, hsync_n=1, vsync_n=1, vblank=1, frame_start=0.
  - Reset has priority over enable.

Test Plan:
- Reset then enable=1 at cycle T: frame_start=1 and rd_en=1 with rd_x=0, rd_y=0 at T+1. de=1 with pixel=rd_data at T+1+RD_LATENCY (T+3 at default). rd_en stays 1 for 640 cycles, then 0 for 160.
- Line timing: with a constant rd_data=4'hA, per 800-cycle line de is high for 640 cycles with pixel=A. hsync_n is low for 96 cycles starting 656 cycles after de rises. pixel=0 outside de.
- Frame timing: vblank rises at v=480, h=0. vsync_n is low for lines 490-491 (2x800 cycles, delayed RD_LATENCY). frame_start repeats every 420000 cycles.
- Buffer swap: buf_sel toggled mid-frame -> rd_buf unchanged until next frame_start, then equals the new buf_sel.
- Stop/restart:
  - enable=0 at line 100 -> scanout continues to the frame end, then IDLE; rd_en stays 0 and outputs idle after RD_LATENCY.
  - enable re-raised at line 300 of DRAIN -> no gap; next frame_start on schedule.
- Reset mid-frame at h=300, v=200 -> next cycle: all outputs at reset values. Outputs remain idle with enable=0. Re-enable restarts at h=0, v=0.
